// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command-driven initiator for the 32x32 MIPS register file.
// Sequences read port 1 and the write port for single read/write, full dump and
// clear commands, and returns results over a valid/ready response channel.
module regfile_access_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [1:0]           CmdOp,
    input  logic [ADDR_BITS-1:0] CmdAddr,
    input  logic [WIDTH-1:0]     CmdData,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [ADDR_BITS-1:0] RspAddr,
    output logic [WIDTH-1:0]     RspData,
    output logic                 RspLast,
    output logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [WIDTH-1:0]     ReadData1,
    output logic [ADDR_BITS-1:0] WriteRegister,
    output logic [WIDTH-1:0]     WriteData,
    output logic                 RegWrite
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;
    localparam logic [ADDR_BITS-1:0] ONE_IDX  = ADDR_BITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DUMP,
        ST_CLEAR,
        ST_RESP
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WIDTH-1:0]       data_q;
    logic [ADDR_BITS-1:0]   index_q;
    logic [ADDR_BITS-1:0]   rsp_addr_q;
    logic [WIDTH-1:0]       rsp_data_q;
    logic                   rsp_last_q;

    // Command sequencer: latches the command, walks the index and captures response beats.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            index_q    <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CmdValid) begin
                        op_q   <= CmdOp;
                        addr_q <= CmdAddr;
                        data_q <= CmdData;
                        case (CmdOp)
                            OP_READ: state_q <= ST_READ;
                            OP_WRITE: state_q <= ST_WRITE;
                            OP_DUMP: begin
                                index_q <= '0;
                                state_q <= ST_DUMP;
                            end
                            default: begin
                                index_q <= ONE_IDX;
                                state_q <= ST_CLEAR;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    rsp_data_q <= ReadData1;
                    rsp_addr_q <= addr_q;
                    rsp_last_q <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_WRITE: begin
                    rsp_data_q <= data_q;
                    rsp_addr_q <= addr_q;
                    rsp_last_q <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_DUMP: begin
                    rsp_data_q <= ReadData1;
                    rsp_addr_q <= index_q;
                    rsp_last_q <= (index_q == LAST_IDX);
                    state_q    <= ST_RESP;
                end
                ST_CLEAR: begin
                    // Terminate on the last index before incrementing so the index never wraps.
                    if (index_q == LAST_IDX) begin
                        rsp_data_q <= WIDTH'(LAST_IDX);
                        rsp_addr_q <= LAST_IDX;
                        rsp_last_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end else begin
                        index_q <= index_q + ONE_IDX;
                    end
                end
                ST_RESP: begin
                    if (RspReady) begin
                        if (op_q == OP_DUMP && !rsp_last_q) begin
                            index_q <= index_q + ONE_IDX;
                            state_q <= ST_DUMP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign CmdReady = (state_q == ST_IDLE);
    assign RspValid = (state_q == ST_RESP);
    assign RspAddr  = rsp_addr_q;
    assign RspData  = rsp_data_q;
    assign RspLast  = rsp_last_q;

    // Register-file port decode; the write port is gated off while reset is asserted.
    always_comb begin
        ReadRegister1 = '0;
        WriteRegister = '0;
        WriteData     = '0;
        RegWrite      = 1'b0;
        case (state_q)
            ST_READ: ReadRegister1 = addr_q;
            ST_DUMP: ReadRegister1 = index_q;
            ST_WRITE: begin
                if (ResetN) begin
                    RegWrite      = 1'b1;
                    WriteRegister = addr_q;
                    WriteData     = data_q;
                end
            end
            ST_CLEAR: begin
                if (ResetN) begin
                    RegWrite      = 1'b1;
                    WriteRegister = index_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: bench with a behavioural register file, an expected
// architectural-state model and per-cycle response/write checking.
module tb_regfile_access_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned AB = 5;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic          Clk = 1'b0;
    logic          ResetN;
    logic          CmdValid;
    logic          CmdReady;
    logic [1:0]    CmdOp;
    logic [AB-1:0] CmdAddr;
    logic [W-1:0]  CmdData;
    logic          RspValid;
    logic          RspReady;
    logic [AB-1:0] RspAddr;
    logic [W-1:0]  RspData;
    logic          RspLast;
    logic [AB-1:0] ReadRegister1;
    logic [W-1:0]  ReadData1;
    logic [AB-1:0] WriteRegister;
    logic [W-1:0]  WriteData;
    logic          RegWrite;

    regfile_access_ctrl #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
        .CmdAddr(CmdAddr), .CmdData(CmdData),
        .RspValid(RspValid), .RspReady(RspReady), .RspAddr(RspAddr),
        .RspData(RspData), .RspLast(RspLast),
        .ReadRegister1(ReadRegister1), .ReadData1(ReadData1),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    always #5 Clk = ~Clk;

    // Environment register file: reg 0 hardwired to zero, not affected by ResetN.
    logic [W-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge Clk) if (RegWrite && WriteRegister != 0) rf[WriteRegister] <= WriteData;
    assign ReadData1 = rf[ReadRegister1];

    // Expected architectural state and expected traffic.
    typedef struct { logic [AB-1:0] addr; logic [W-1:0] data; logic last; } rsp_t;
    typedef struct { logic [AB-1:0] addr; logic [W-1:0] data; } wr_t;
    logic [W-1:0] exp_mem [32];
    rsp_t exp_rsp [$];
    wr_t  exp_wr  [$];

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;
    int rsp_beats = 0;
    logic [AB-1:0] last_rsp_addr;
    logic [W-1:0]  last_rsp_data;
    logic          last_rsp_last;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of write port and response channel against the expectations.
    always @(negedge Clk) begin
        if (chk_en) begin
            if (RegWrite) begin
                wr_cycles++;
                check(ReadRegister1 == 0, "rr1_idle_during_write", W'(ReadRegister1), 0);
                if (exp_wr.size() == 0) begin
                    check(1'b0, "unexpected_write", W'(WriteRegister), 0);
                end else begin
                    check(WriteRegister === exp_wr[0].addr, "write_addr", W'(WriteRegister), W'(exp_wr[0].addr));
                    check(WriteData === exp_wr[0].data, "write_data", WriteData, exp_wr[0].data);
                    void'(exp_wr.pop_front());
                end
            end else begin
                check(WriteRegister === '0 && WriteData === '0, "write_port_quiet", WriteData, 0);
            end
            if (RspValid) begin
                check(!CmdReady, "cmdready_during_rsp", W'(CmdReady), 0);
                if (exp_rsp.size() == 0) begin
                    check(1'b0, "unexpected_rsp", RspData, 0);
                end else begin
                    check(RspAddr === exp_rsp[0].addr, "rsp_addr", W'(RspAddr), W'(exp_rsp[0].addr));
                    check(RspData === exp_rsp[0].data, "rsp_data", RspData, exp_rsp[0].data);
                    check(RspLast === exp_rsp[0].last, "rsp_last", W'(RspLast), W'(exp_rsp[0].last));
                    if (RspReady) begin
                        rsp_beats++;
                        last_rsp_addr = RspAddr;
                        last_rsp_data = RspData;
                        last_rsp_last = RspLast;
                        void'(exp_rsp.pop_front());
                    end
                end
            end
        end
    end

    // Response-side consumer: always ready, or random backpressure.
    initial begin
        RspReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            RspReady = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Record what a command must produce, then present it until accepted.
    task automatic issue(input logic [1:0] op, input logic [AB-1:0] addr, input logic [W-1:0] data);
        bit acc;
        case (op)
            OP_READ: exp_rsp.push_back('{addr, exp_mem[addr], 1'b1});
            OP_WRITE: begin
                exp_wr.push_back('{addr, data});
                exp_rsp.push_back('{addr, data, 1'b1});
                if (addr != 0) exp_mem[addr] = data;
            end
            OP_DUMP: for (int i = 0; i < 32; i++) exp_rsp.push_back('{AB'(i), exp_mem[i], i == 31});
            default: begin
                for (int k = 1; k < 32; k++) begin
                    exp_wr.push_back('{AB'(k), '0});
                    exp_mem[k] = '0;
                end
                exp_rsp.push_back('{AB'(31), W'(31), 1'b1});
            end
        endcase
        @(posedge Clk);
        #1;
        CmdValid = 1'b1; CmdOp = op; CmdAddr = addr; CmdData = data;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge Clk);
            if (CmdReady) begin
                @(posedge Clk);
                acc = 1'b1;
            end
        end
        if (!acc) check(1'b0, "cmd_accept_timeout", 0, 1);
        #1;
        CmdValid = 1'b0; CmdOp = '0; CmdAddr = '0; CmdData = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge Clk);
            if (exp_rsp.size() == 0 && exp_wr.size() == 0 && CmdReady) done = 1'b1;
        end
        if (!done) check(1'b0, "idle_timeout", W'(exp_rsp.size()), 0);
    endtask

    initial begin
        int wr0, beats0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        ResetN = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdAddr = '0; CmdData = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check(RspValid === 1'b0, "reset_rspvalid", W'(RspValid), 0);
        check(RegWrite === 1'b0, "reset_regwrite", W'(RegWrite), 0);
        check(CmdReady === 1'b1, "reset_cmdready", W'(CmdReady), 1);
        #1 ResetN = 1'b1;
        chk_en = 1'b1;

        // Regfile reads zero after reset.
        issue(OP_READ, 5'd7, '0); wait_idle();
        issue(OP_READ, 5'd31, '0); wait_idle();

        // WRITE 5, then READ 5 with latency checks.
        wr0 = wr_cycles;
        issue(OP_WRITE, 5'd5, 32'hDEADBEEF); wait_idle();
        check(wr_cycles - wr0 == 1, "write_pulse_count", W'(wr_cycles - wr0), 1);
        check(last_rsp_data === 32'hDEADBEEF && last_rsp_addr === 5'd5 && last_rsp_last,
              "write_echo_literal", last_rsp_data, 32'hDEADBEEF);
        issue(OP_READ, 5'd5, '0);
        @(negedge Clk);
        check(RspValid === 1'b0, "read_lat_e0", W'(RspValid), 0);
        @(negedge Clk);
        check(RspValid === 1'b1, "read_lat_e1", W'(RspValid), 1);
        @(negedge Clk);
        check(CmdReady === 1'b1, "read_lat_e2_ready", W'(CmdReady), 1);
        wait_idle();
        check(last_rsp_data === 32'hDEADBEEF, "read5_literal", last_rsp_data, 32'hDEADBEEF);

        // Write to register 0 is discarded by the regfile.
        issue(OP_WRITE, 5'd0, 32'h12345678); wait_idle();
        issue(OP_READ, 5'd0, '0); wait_idle();
        check(last_rsp_data === 32'h0, "read0_literal", last_rsp_data, 0);

        // Fill 1..31 then DUMP under random backpressure.
        for (int k = 1; k < 32; k++) begin
            issue(OP_WRITE, AB'(k), W'(32'h100 + k)); wait_idle();
        end
        rand_mode = 1'b1;
        beats0 = rsp_beats;
        issue(OP_DUMP, '0, '0); wait_idle();
        check(rsp_beats - beats0 == 32, "dump_beats", W'(rsp_beats - beats0), 32);
        check(last_rsp_data === 32'h11F && last_rsp_addr === 5'd31 && last_rsp_last,
              "dump_last_literal", last_rsp_data, 32'h11F);

        // CLEAR then DUMP of zeros.
        wr0 = wr_cycles;
        issue(OP_CLEAR, '0, '0); wait_idle();
        check(wr_cycles - wr0 == 31, "clear_write_count", W'(wr_cycles - wr0), 31);
        check(last_rsp_data === 32'd31 && last_rsp_addr === 5'd31, "clear_rsp_literal", last_rsp_data, 31);
        issue(OP_DUMP, '0, '0); wait_idle();
        rand_mode = 1'b0;

        // Reset in the middle of a CLEAR, while register 10 is being written.
        for (int k = 1; k < 32; k++) begin
            issue(OP_WRITE, AB'(k), W'(32'h200 + k)); wait_idle();
        end
        issue(OP_CLEAR, '0, '0);
        repeat (9) @(posedge Clk);
        #1;
        check(RegWrite === 1'b1 && WriteRegister === 5'd10, "clear_at_10", W'(WriteRegister), 10);
        ResetN = 1'b0;
        #1;
        check(RegWrite === 1'b0, "regwrite_drops_on_reset", W'(RegWrite), 0);
        exp_wr.delete();
        exp_rsp.delete();
        for (int k = 10; k < 32; k++) exp_mem[k] = W'(32'h200 + k);
        repeat (2) @(posedge Clk);
        #1 ResetN = 1'b1;
        @(negedge Clk);
        check(CmdReady === 1'b1 && RspValid === 1'b0, "abort_idle", W'({CmdReady, RspValid}), 2);
        check(rf[9] === 32'h0 && rf[10] === 32'h20A && rf[31] === 32'h21F, "abort_regs_literal", rf[10], 32'h20A);
        rand_mode = 1'b1;
        issue(OP_DUMP, '0, '0); wait_idle();
        rand_mode = 1'b0;
        repeat (3) @(posedge Clk);
        check(exp_rsp.size() == 0 && exp_wr.size() == 0, "queues_drained", W'(exp_rsp.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Command-driven initiator for the 32x32 MIPS register file. Accepts single-register read/write, full dump, and clear commands over a valid/ready command channel. Sequences the register file's read-port-1 and write-port signals, and returns results over a valid/ready response channel. Used by the debug/test harness to load and inspect architectural state without the CPU datapath.

Parameters:
WIDTH, 32, data width of register file words
ADDR_BITS, 5, register address width; depth is 2**ADDR_BITS (32)

Ports:
Clk  input  1  clock, positive edge
ResetN  input  1  synchronous, active-low reset
CmdValid  input  1  command present
CmdReady  output  1  controller can accept a command
CmdOp  input  2  00=READ, 01=WRITE, 10=DUMP, 11=CLEAR
CmdAddr  input  ADDR_BITS  target register (READ/WRITE only)
CmdData  input  WIDTH  write data (WRITE only)
RspValid  output  1  response present
RspReady  input  1  consumer accepts response
RspAddr  output  ADDR_BITS  register the response refers to
RspData  output  WIDTH  read data, write echo, or clear count
RspLast  output  1  final beat of the command's response
ReadRegister1  output  ADDR_BITS  to regfile read port 1 address
ReadData1  input  WIDTH  from regfile read port 1 (asynchronous)
WriteRegister  output  ADDR_BITS  to regfile write address
WriteData  output  WIDTH  to regfile write data
RegWrite  output  1  to regfile write enable

Behaviour:
- Reset is synchronous, active-low, single clock Clk. At any edge with ResetN=0:
  - state<=IDLE, index<=0, all latched fields<=0.
  - RspValid=0, CmdReady=1 after reset.
  - RegWrite is forced 0 combinationally while ResetN=0.
  - Reset mid-command aborts it with no further writes and no response.
- States: IDLE, READ, WRITE, DUMP, CLEAR, RESP.
- IDLE:
  - CmdReady=1. On CmdValid&CmdReady at edge E0, latch op/addr/data and go to the op's state.
  - CmdReady=0 in every other state; commands are never queued.
- READ (one cycle):
  - ReadRegister1=latched addr.
  - At the next edge, RspData<=ReadData1, RspAddr<=addr, RspLast<=1, go RESP.
- WRITE (one cycle):
  - WriteRegister=addr, WriteData=data, RegWrite=1.
  - At the next edge, RspData<=data (echo), RspAddr<=addr, RspLast<=1, go RESP.
  - A write to register 0 is issued normally; the regfile discards it.
- DUMP:
  - index starts at 0. Each DUMP cycle drives ReadRegister1=index.
  - At the next edge, RspData<=ReadData1, RspAddr<=index, RspLast<=(index==31), go RESP.
  - On RESP handshake: if index==31, go IDLE; else index<=index+1 and go DUMP.
  - Result is exactly 32 beats, addresses 0..31 in order, each beat at least 2 cycles.
- CLEAR:
  - index starts at 1. Each cycle drives RegWrite=1, WriteRegister=index, WriteData=0, and index increments.
  - After the cycle writing 31, RspData<=31 (registers cleared), RspAddr<=31, RspLast<=1, go RESP.
  - Register 0 is never addressed. Exactly 31 consecutive write cycles.
- RESP:
  - RspValid=1. RspAddr/RspData/RspLast are registered and held stable until RspValid&RspReady.
  - The handshake edge leaves RESP: to IDLE, or back to DUMP for the next beat.
- Latency, counted from acceptance edge E0:
  - READ/WRITE: RspValid high in the cycle after edge E0+1. With RspReady=1 at the next edge, CmdReady returns in the cycle after E0+2.
  - CLEAR: writes commit at edges E0+1..E0+31; RspValid high after edge E0+31.
- RegWrite is high only in the WRITE and CLEAR states. ReadRegister1 is 0 outside READ/DUMP. WriteRegister/WriteData are 0 when RegWrite=0.
- Backpressure: RspReady may be held low indefinitely with no state change, no writes, and stable outputs.
- Index arithmetic is ADDR_BITS wide. Termination is detected on index==31 before increment, so no wrap occurs.

Test Plan:
- Reset: hold ResetN=0 for 2 cycles -> RspValid=0, RegWrite=0, CmdReady=1; all regfile reads return 0.
- WRITE addr=5 data=0xDEADBEEF, then READ addr=5 -> write response RspData=0xDEADBEEF, RspAddr=5, RspLast=1; read response RspData=0xDEADBEEF; RegWrite pulses exactly one cycle.
- WRITE addr=0 data=0x12345678, then READ 0 -> RspData=0x00000000.
- Write reg k = 0x100+k for k=1..31, then DUMP with RspReady toggling randomly -> 32 beats, RspAddr 0..31 in order, data 0,0x101..0x11F, RspLast only on beat 31, data stable while stalled.
- CLEAR after the above -> exactly 31 RegWrite cycles to addresses 1..31 with WriteData=0; one response RspData=31, RspLast=1; a following DUMP returns all zeros.
- Assert ResetN=0 during CLEAR at index 10 -> RegWrite drops immediately, no response; registers 1..9 are zero, 10..31 unchanged; CmdReady=1 after reset.
